// File: rtl/id_exe_stage_reg_if.sv
// ID/EXE pipeline-register bundle: ID-side inputs, EXE-side outputs, stall and event counters.
// The master modport is the surrounding core (or a bench); the slave modport is the stage register.
interface id_exe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic              id_valid_i;
    logic [4:0]        id_rs1_i;
    logic [4:0]        id_rs2_i;
    logic [4:0]        id_rd_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [7:0]        id_ctrl_i;
    logic [DATA_W-1:0] id_rs1_data_i;
    logic [DATA_W-1:0] id_rs2_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [DATA_W-1:0] id_pc_i;

    logic              stall_o;
    logic              exe_valid_o;
    logic [4:0]        exe_rs1_o;
    logic [4:0]        exe_rs2_o;
    logic [4:0]        exe_rd_o;
    logic [7:0]        exe_ctrl_o;
    logic [DATA_W-1:0] exe_rs1_data_o;
    logic [DATA_W-1:0] exe_rs2_data_o;
    logic [DATA_W-1:0] exe_imm_o;
    logic [DATA_W-1:0] exe_pc_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;

    modport master (
        output flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_use_rs1_i, id_use_rs2_i, id_ctrl_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
        input  stall_o, exe_valid_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_ctrl_o,
               exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_pc_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  flush_i, id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_use_rs1_i, id_use_rs2_i, id_ctrl_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i,
        output stall_o, exe_valid_o, exe_rs1_o, exe_rs2_o, exe_rd_o, exe_ctrl_o,
               exe_rs1_data_o, exe_rs2_data_o, exe_imm_o, exe_pc_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with load-use hazard detection, bubble insertion and branch flush.
// Optional stall/flush event counters are built only when ID_EXE_PERF_CNT_EN is defined.
module id_exe_stage_reg #(
    parameter int DATA_W = 32
) (
    input logic               clk_i,
    input logic               rst_i,
    id_exe_stage_reg_if.slave bus
);
    // Control packing: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp[1:0]}
    localparam int CTRL_MEMREAD = 6;
    localparam int N_DATA       = 4;

    logic              r_exe_valid;
    logic [4:0]        r_exe_rs1;
    logic [4:0]        r_exe_rs2;
    logic [4:0]        r_exe_rd;
    logic [7:0]        r_exe_ctrl;
    logic [DATA_W-1:0] r_exe_data [N_DATA];
    logic [DATA_W-1:0] w_id_data  [N_DATA];

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hz;
    logic w_stall;
    logic w_bubble;

    assign w_rs1_match = bus.id_use_rs1_i && (bus.id_rs1_i == r_exe_rd);
    assign w_rs2_match = bus.id_use_rs2_i && (bus.id_rs2_i == r_exe_rd);

    // A load writing x0 produces nothing to wait for, so it never stalls.
    assign w_hz = r_exe_valid && r_exe_ctrl[CTRL_MEMREAD] && (r_exe_rd != 5'd0) &&
                  bus.id_valid_i && (w_rs1_match || w_rs2_match);

    assign w_stall  = w_hz && !bus.flush_i;
    assign w_bubble = bus.flush_i || w_hz;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_exe_valid <= 1'b0;
            r_exe_ctrl  <= 8'd0;
            r_exe_rd    <= 5'd0;
            r_exe_rs1   <= 5'd0;
            r_exe_rs2   <= 5'd0;
        end else if (w_bubble) begin
            // Bubble clears only what downstream stages act on; operands simply hold.
            r_exe_valid <= 1'b0;
            r_exe_ctrl  <= 8'd0;
            r_exe_rd    <= 5'd0;
        end else begin
            r_exe_valid <= bus.id_valid_i;
            r_exe_ctrl  <= bus.id_valid_i ? bus.id_ctrl_i : 8'd0;
            r_exe_rd    <= bus.id_rd_i;
            r_exe_rs1   <= bus.id_rs1_i;
            r_exe_rs2   <= bus.id_rs2_i;
        end
    end

    assign w_id_data[0] = bus.id_rs1_data_i;
    assign w_id_data[1] = bus.id_rs2_data_i;
    assign w_id_data[2] = bus.id_imm_i;
    assign w_id_data[3] = bus.id_pc_i;

    generate
        for (genvar gi = 0; gi < N_DATA; gi++) begin : g_data
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_exe_data[gi] <= '0;
                end else if (!w_bubble) begin
                    r_exe_data[gi] <= w_id_data[gi];
                end
            end
        end
    endgenerate

    assign bus.stall_o        = w_stall;
    assign bus.exe_valid_o    = r_exe_valid;
    assign bus.exe_rs1_o      = r_exe_rs1;
    assign bus.exe_rs2_o      = r_exe_rs2;
    assign bus.exe_rd_o       = r_exe_rd;
    assign bus.exe_ctrl_o     = r_exe_ctrl;
    assign bus.exe_rs1_data_o = r_exe_data[0];
    assign bus.exe_rs2_data_o = r_exe_data[1];
    assign bus.exe_imm_o      = r_exe_data[2];
    assign bus.exe_pc_o       = r_exe_data[3];

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.flush_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
`else
    assign bus.stall_cnt_o = 32'd0;
    assign bus.flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg: reset, load-use stall, x0 / unused-rs2
// non-stalls, flush priority, pass-through and counters (expectations follow ID_EXE_PERF_CNT_EN).
module tb_id_exe_stage_reg;
    localparam int DATA_W = 32;

    localparam logic [7:0] CTRL_LW  = 8'hD8; // RegWrite MemRead MemtoReg ALUSrc
    localparam logic [7:0] CTRL_ALU = 8'h82; // RegWrite ALUOp=10
    localparam logic [7:0] CTRL_SW  = 8'h28; // MemWrite ALUSrc

`ifdef ID_EXE_PERF_CNT_EN
    localparam logic [31:0] CNT_ON = 32'd1;
`else
    localparam logic [31:0] CNT_ON = 32'd0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    id_exe_stage_reg_if #(.DATA_W(DATA_W)) bus ();

    id_exe_stage_reg #(.DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("chk %s ok val=%0h", tag, got);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic [7:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [31:0] pc);
        bus.id_valid_i    = v;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_use_rs1_i  = u1;
        bus.id_use_rs2_i  = u2;
        bus.id_ctrl_i     = ctrl;
        bus.id_rs1_data_i = d1;
        bus.id_rs2_data_i = d2;
        bus.id_imm_i      = imm;
        bus.id_pc_i       = pc;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.flush_i = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) cyc();
        rst_n = 1'b1;

        // Load a real instruction, then assert reset mid-cycle with valid input present.
        drive_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, CTRL_ALU, 32'hAAAA, 32'hBBBB, 32'h10, 32'h40);
        cyc();
        check("pre_rst_valid", {63'd0, bus.exe_valid_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_valid", {63'd0, bus.exe_valid_o}, 64'd0);
        check("rst_ctrl", {56'd0, bus.exe_ctrl_o}, 64'd0);
        check("rst_addr", {49'd0, bus.exe_rs1_o, bus.exe_rs2_o, bus.exe_rd_o}, 64'd0);
        check("rst_data01", {bus.exe_rs1_data_o, bus.exe_rs2_data_o}, 64'd0);
        check("rst_data23", {bus.exe_imm_o, bus.exe_pc_o}, 64'd0);
        check("rst_stall", {63'd0, bus.stall_o}, 64'd0);
        cyc();
        rst_n = 1'b1;

        // Load-use: lw x5 then add x6,x5,x7.
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW, 32'h100, 32'h0, 32'd4, 32'h200);
        check("lw_id_stall", {63'd0, bus.stall_o}, 64'd0);
        cyc();
        check("lw_exe_rd", {59'd0, bus.exe_rd_o}, 64'd5);
        check("lw_exe_ctrl", {56'd0, bus.exe_ctrl_o}, {56'd0, CTRL_LW});
        check("lw_exe_imm", {32'd0, bus.exe_imm_o}, 64'd4);
        drive_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ALU, 32'h55, 32'h77, 32'd0, 32'h204);
        check("lu_stall", {63'd0, bus.stall_o}, 64'd1);
        cyc();
        check("lu_bubble_ctrl", {56'd0, bus.exe_ctrl_o}, 64'd0);
        check("lu_bubble_valid", {63'd0, bus.exe_valid_o}, 64'd0);
        check("lu_bubble_rd", {59'd0, bus.exe_rd_o}, 64'd0);
        check("lu_stall_once", {63'd0, bus.stall_o}, 64'd0);
        cyc();
        check("lu_exe_rs1", {59'd0, bus.exe_rs1_o}, 64'd5);
        check("lu_exe_rd", {59'd0, bus.exe_rd_o}, 64'd6);
        check("lu_exe_ctrl", {56'd0, bus.exe_ctrl_o}, {56'd0, CTRL_ALU});
        check("lu_exe_data", {bus.exe_rs1_data_o, bus.exe_rs2_data_o}, 64'h00000055_00000077);
        check("lu_exe_pc", {32'd0, bus.exe_pc_o}, 64'h204);
        check("lu_stall_cnt", {32'd0, bus.stall_cnt_o}, {32'd0, CNT_ON});

        // lw x0 followed by a reader of x0: no stall.
        drive_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW, 32'h0, 32'h0, 32'd8, 32'h208);
        cyc();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, CTRL_ALU, 32'h0, 32'h0, 32'd0, 32'h20C);
        check("x0_no_stall", {63'd0, bus.stall_o}, 64'd0);

        // lw x5 followed by sw whose rs2=5 is flagged unused, then flagged used.
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW, 32'h100, 32'h0, 32'd4, 32'h210);
        cyc();
        drive_id(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b0, CTRL_SW, 32'h22, 32'h55, 32'd12, 32'h214);
        check("rs2_unused_no_stall", {63'd0, bus.stall_o}, 64'd0);
        drive_id(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, CTRL_SW, 32'h22, 32'h55, 32'd12, 32'h214);
        check("rs2_used_stall", {63'd0, bus.stall_o}, 64'd1);

        // Flush in the same cycle as the hazard: flush wins.
        bus.flush_i = 1'b1;
        #1;
        check("flush_masks_stall", {63'd0, bus.stall_o}, 64'd0);
        cyc();
        bus.flush_i = 1'b0;
        check("flush_valid", {63'd0, bus.exe_valid_o}, 64'd0);
        check("flush_ctrl", {56'd0, bus.exe_ctrl_o}, 64'd0);
        check("flush_cnt", {32'd0, bus.flush_cnt_o}, {32'd0, CNT_ON});
        check("flush_stall_cnt", {32'd0, bus.stall_cnt_o}, {32'd0, CNT_ON});

        // Four independent ALU ops pass straight through, one cycle each.
        for (int k = 0; k < 4; k++) begin
            drive_id(1'b1, 5'(20 + k), 5'(25 + k), 5'(10 + k), 1'b1, 1'b1, CTRL_ALU,
                     32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'h30 + 32'(k), 32'h300 + 32'(4 * k));
            check($sformatf("pt%0d_stall", k), {63'd0, bus.stall_o}, 64'd0);
            cyc();
            check($sformatf("pt%0d_addr", k), {49'd0, bus.exe_rs1_o, bus.exe_rs2_o, bus.exe_rd_o},
                  {49'd0, 5'(20 + k), 5'(25 + k), 5'(10 + k)});
            check($sformatf("pt%0d_data", k), {bus.exe_rs1_data_o, bus.exe_rs2_data_o},
                  {32'h1000 + 32'(k), 32'h2000 + 32'(k)});
            check($sformatf("pt%0d_pc", k), {32'd0, bus.exe_pc_o}, {32'd0, 32'h300 + 32'(4 * k)});
        end
        check("pt_stall_cnt", {32'd0, bus.stall_cnt_o}, {32'd0, CNT_ON});

        // Invalid ID slot: control must be squashed even if the decoder drives garbage.
        drive_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, CTRL_LW, 32'h0, 32'h0, 32'd0, 32'h400);
        cyc();
        check("inv_valid", {63'd0, bus.exe_valid_o}, 64'd0);
        check("inv_ctrl", {56'd0, bus.exe_ctrl_o}, 64'd0);

        // Reset asserted mid-stall clears everything at once; no stall after release.
        drive_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, CTRL_LW, 32'h100, 32'h0, 32'd4, 32'h500);
        cyc();
        drive_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, CTRL_ALU, 32'h55, 32'h77, 32'd0, 32'h504);
        check("rs_pre_stall", {63'd0, bus.stall_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rs_stall", {63'd0, bus.stall_o}, 64'd0);
        check("rs_valid", {63'd0, bus.exe_valid_o}, 64'd0);
        check("rs_rd", {59'd0, bus.exe_rd_o}, 64'd0);
        check("rs_cnts", {bus.stall_cnt_o, bus.flush_cnt_o}, 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("rs_release_stall", {63'd0, bus.stall_o}, 64'd0);
        cyc();
        check("rs_release_rd", {59'd0, bus.exe_rd_o}, 64'd6);
        check("rs_release_valid", {63'd0, bus.exe_valid_o}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
